integer_literal_evaluator: RTL and testbench

INTEGER_LITERAL_EVALUATOR -- requirements
Module: integer_literal_evaluator

---
 rtl/integer_literal_evaluator.sv | 127 ++++++++++++
 tb/tb_integer_literal_evaluator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integer_literal_evaluator.sv
// Integer literal evaluator.
//
// Evaluates one linear integer literal  sum(c_i * x_i) <= bound  over
// NUMBER_OF_INTEGER_VARIABLES signed coefficient/value pairs. Each pair is
// multiplied and accumulated on its own cycle. The signed comparison against
// the bound follows in one extra cycle.
//
// Ports:
//   in_clk                  rising-edge clock
//   in_reset                asynchronous active-low reset
//   in_start                request one evaluation (sampled only in IDLE)
//   in_clause_coefficients  packed signed coefficients, element i at [i*W +: W]
//   in_variable_values      packed signed variable values, same packing
//   in_bound                signed literal bound
//   out_busy                high while accumulating or comparing
//   out_done                one-cycle pulse when out_sum/out_satisfied are valid
//   out_satisfied           1 when the dot product is <= bound; held until next done
//   out_sum                 signed dot product; held until next done
module integer_literal_evaluator #(
    parameter int unsigned BIT_WIDTH_OF_INTEGER_VARIABLE = 4,
    parameter int unsigned NUMBER_OF_INTEGER_VARIABLES   = 4,
    parameter int unsigned BIT_WIDTH_OF_ACCUMULATOR      = 12
) (
    input  logic                                   in_clk,
    input  logic                                   in_reset,
    input  logic                                   in_start,
    input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES-1:0]
                                                   in_clause_coefficients,
    input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES-1:0]
                                                   in_variable_values,
    input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_bound,
    output logic                                   out_busy,
    output logic                                   out_done,
    output logic                                   out_satisfied,
    output logic signed [BIT_WIDTH_OF_ACCUMULATOR-1:0] out_sum
);

    localparam int W     = BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int N     = NUMBER_OF_INTEGER_VARIABLES;
    localparam int ACC   = BIT_WIDTH_OF_ACCUMULATOR;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StCompare
    } state_e;

    state_e                  state_q;
    logic [W*N-1:0]          coef_q;
    logic [W*N-1:0]          val_q;
    logic signed [W-1:0]     bound_q;
    logic signed [ACC-1:0]   acc_q;
    logic [IDX_W-1:0]        index_q;

    logic signed [W-1:0]     cur_coef;
    logic signed [W-1:0]     cur_val;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC-1:0]   prod_ext;
    logic signed [ACC-1:0]   bound_ext;
    logic                    last_index;
    logic                    acc_le_bound;

    always_comb begin
        cur_coef     = coef_q[int'(index_q)*W +: W];
        cur_val      = val_q[int'(index_q)*W +: W];
        // Full-width signed product, then sign-extend into the accumulator.
        prod         = cur_coef * cur_val;
        prod_ext     = ACC'(prod);
        bound_ext    = ACC'(bound_q);
        last_index   = (index_q == IDX_W'(N - 1));
        acc_le_bound = (acc_q <= bound_ext);
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q       <= StIdle;
            coef_q        <= '0;
            val_q         <= '0;
            bound_q       <= '0;
            acc_q         <= '0;
            index_q       <= '0;
            out_busy      <= 1'b0;
            out_done      <= 1'b0;
            out_satisfied <= 1'b0;
            out_sum       <= '0;
        end else begin
            out_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_start) begin
                        // Operands are captured here so later bus changes
                        // cannot disturb the running evaluation.
                        coef_q   <= in_clause_coefficients;
                        val_q    <= in_variable_values;
                        bound_q  <= in_bound;
                        acc_q    <= '0;
                        index_q  <= '0;
                        state_q  <= StAccum;
                        out_busy <= 1'b1;
                    end
                end
                StAccum: begin
                    acc_q <= acc_q + prod_ext;
                    if (last_index) begin
                        index_q <= '0;
                        state_q <= StCompare;
                    end else begin
                        index_q <= index_q + IDX_W'(1);
                    end
                end
                StCompare: begin
                    out_sum       <= acc_q;
                    out_satisfied <= acc_le_bound;
                    out_done      <= 1'b1;
                    out_busy      <= 1'b0;
                    state_q       <= StIdle;
                end
                default: begin
                    state_q  <= StIdle;
                    out_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_integer_literal_evaluator.sv
module tb_integer_literal_evaluator;

    logic               in_clk;
    logic               in_reset;
    logic               in_start;
    logic [15:0]        in_clause_coefficients;
    logic [15:0]        in_variable_values;
    logic [3:0]         in_bound;
    logic               out_busy;
    logic               out_done;
    logic               out_satisfied;
    logic signed [11:0] out_sum;

    int checks;
    int failures;

    integer_literal_evaluator #(
        .BIT_WIDTH_OF_INTEGER_VARIABLE (4),
        .NUMBER_OF_INTEGER_VARIABLES   (4),
        .BIT_WIDTH_OF_ACCUMULATOR      (12)
    ) dut (
        .in_clk                 (in_clk),
        .in_reset               (in_reset),
        .in_start               (in_start),
        .in_clause_coefficients (in_clause_coefficients),
        .in_variable_values     (in_variable_values),
        .in_bound               (in_bound),
        .out_busy               (out_busy),
        .out_done               (out_done),
        .out_satisfied          (out_satisfied),
        .out_sum                (out_sum)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Element 0 lands in the least significant nibble.
    function automatic logic [15:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {e3[3:0], e2[3:0], e1[3:0], e0[3:0]};
    endfunction

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Start one evaluation and wait (bounded) for done. lat=0 means timeout.
    task automatic run_eval(input logic [15:0] c, input logic [15:0] v, input logic [3:0] b,
                            output int lat, output int busy_cnt);
        in_clause_coefficients = c;
        in_variable_values     = v;
        in_bound               = b;
        in_start               = 1'b1;
        tick();
        in_start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (out_busy) busy_cnt++;
            tick();
            if (out_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        in_start = 1'b0;
        in_clause_coefficients = '0;
        in_variable_values     = '0;
        in_bound               = '0;
        #1 in_reset = 1'b0;
        tick();
        tick();
        checks++;
        if (out_busy !== 1'b0 || out_done !== 1'b0 || out_satisfied !== 1'b0 || out_sum !== 12'sd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b sat=%b sum=%0d, required all 0",
                     out_busy, out_done, out_satisfied, out_sum);
        end
        in_reset = 1'b1;
        tick();
        tick();
        checks++;
        if (out_busy !== 1'b0 || out_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_release: busy=%b done=%b, required 0 0", out_busy, out_done);
        end
    endtask

    task automatic test_basic();
        int lat;
        int busy_cnt;
        run_eval(pack4(1, 2, -1, 0), pack4(3, 1, 2, 5), 4'd3, lat, busy_cnt);
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles, required 5", lat);
        end
        checks++;
        if (busy_cnt != 5) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d, required 5", busy_cnt);
        end
        checks++;
        if (out_sum !== 12'sd3 || out_satisfied !== 1'b1) begin
            failures++;
            $display("FAIL basic_result: sum=%0d sat=%b, required sum=3 sat=1", out_sum, out_satisfied);
        end
        checks++;
        if (out_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_at_done: got %b, required 0", out_busy);
        end
        tick();
        checks++;
        if (out_done !== 1'b0 || out_sum !== 12'sd3 || out_satisfied !== 1'b1) begin
            failures++;
            $display("FAIL basic_hold: done=%b sum=%0d sat=%b, required done=0 sum=3 sat=1",
                     out_done, out_sum, out_satisfied);
        end
    endtask

    task automatic test_bound_edge();
        int lat;
        int busy_cnt;
        run_eval(pack4(1, 2, -1, 0), pack4(3, 1, 2, 5), 4'd2, lat, busy_cnt);
        checks++;
        if (lat != 5 || out_sum !== 12'sd3 || out_satisfied !== 1'b0) begin
            failures++;
            $display("FAIL bound2_result: lat=%0d sum=%0d sat=%b, required lat=5 sum=3 sat=0",
                     lat, out_sum, out_satisfied);
        end
    endtask

    task automatic test_extremes();
        int lat;
        int busy_cnt;
        // (-8)*(-8)*4 = 256 > 7
        run_eval(pack4(-8, -8, -8, -8), pack4(-8, -8, -8, -8), 4'd7, lat, busy_cnt);
        checks++;
        if (lat != 5 || out_sum !== 12'sd256 || out_satisfied !== 1'b0) begin
            failures++;
            $display("FAIL extreme_pos: lat=%0d sum=%0d sat=%b, required lat=5 sum=256 sat=0",
                     lat, out_sum, out_satisfied);
        end
        // 7*(-8)*4 = -224 <= -8
        run_eval(pack4(7, 7, 7, 7), pack4(-8, -8, -8, -8), 4'b1000, lat, busy_cnt);
        checks++;
        if (lat != 5 || out_sum !== -12'sd224 || out_satisfied !== 1'b1) begin
            failures++;
            $display("FAIL extreme_neg: lat=%0d sum=%0d sat=%b, required lat=5 sum=-224 sat=1",
                     lat, out_sum, out_satisfied);
        end
    endtask

    task automatic test_capture_ignore();
        int dones;
        in_clause_coefficients = pack4(1, 2, -1, 0);
        in_variable_values     = pack4(3, 1, 2, 5);
        in_bound               = 4'd3;
        in_start               = 1'b1;
        tick();
        in_start               = 1'b0;
        dones                  = 0;
        tick();
        in_clause_coefficients = pack4(7, 7, 7, 7);
        in_variable_values     = pack4(7, 7, 7, 7);
        in_bound               = 4'b1000;
        in_start               = 1'b1;
        tick();
        in_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_done) begin
                dones++;
                checks++;
                if (out_sum !== 12'sd3 || out_satisfied !== 1'b1) begin
                    failures++;
                    $display("FAIL capture_result: sum=%0d sat=%b, required sum=3 sat=1",
                             out_sum, out_satisfied);
                end
            end
            tick();
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL capture_done_count: got %0d, required 1", dones);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int busy_cnt;
        int dones;
        in_clause_coefficients = pack4(1, 2, -1, 0);
        in_variable_values     = pack4(3, 1, 2, 5);
        in_bound               = 4'd3;
        in_start               = 1'b1;
        tick();
        in_start = 1'b0;
        tick();
        // Mid-cycle, second ACCUM cycle: reset must act without a clock edge.
        #2 in_reset = 1'b0;
        #1;
        checks++;
        if (out_busy !== 1'b0 || out_done !== 1'b0 || out_satisfied !== 1'b0 || out_sum !== 12'sd0) begin
            failures++;
            $display("FAIL abort_outputs: busy=%b done=%b sat=%b sum=%0d, required all 0",
                     out_busy, out_done, out_satisfied, out_sum);
        end
        dones = 0;
        tick();
        in_reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (out_done) dones++;
            tick();
        end
        checks++;
        if (dones != 0 || out_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: dones=%0d busy=%b, required 0 0", dones, out_busy);
        end
        run_eval(pack4(1, 2, -1, 0), pack4(3, 1, 2, 5), 4'd3, lat, busy_cnt);
        checks++;
        if (lat != 5 || out_sum !== 12'sd3 || out_satisfied !== 1'b1) begin
            failures++;
            $display("FAIL abort_recover: lat=%0d sum=%0d sat=%b, required lat=5 sum=3 sat=1",
                     lat, out_sum, out_satisfied);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int last_k;
        tick();
        // Coeffs {2,0,0,0} x values {-3,...} -> -6, satisfied against bound -6.
        in_clause_coefficients = pack4(2, 0, 0, 0);
        in_variable_values     = pack4(-3, 0, 0, 0);
        in_bound               = 4'b1010;
        in_start               = 1'b1;
        dones                  = 0;
        last_k                 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (out_done) begin
                dones++;
                if (dones > 1) begin
                    checks++;
                    if (k - last_k != 6) begin
                        failures++;
                        $display("FAIL b2b_spacing: got %0d cycles, required 6", k - last_k);
                    end
                end
                last_k = k;
            end
            if (dones > 0) begin
                checks++;
                if (out_sum !== -12'sd6 || out_satisfied !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_stable: cycle %0d sum=%0d sat=%b, required sum=-6 sat=1",
                             k, out_sum, out_satisfied);
                end
            end
        end
        in_start = 1'b0;
        checks++;
        if (dones != 3) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d, required 3", dones);
        end
        for (int k = 0; k < 8; k++) tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_bound_edge();
        test_extremes();
        test_capture_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
